muldiv_unit: RTL and testbench

//  Multi-cycle M-extension execution unit beside the combinational alu in the EX stage.
//  - Accepts the same operands and 6-bit SELECT codes 001000..001111 (MUL..REMU).
//  - Replaces the single-cycle divide path with a sequential restoring divider.
//  - Reports completion so the pipeline control stalls EX/MEM until DONE.
//  - RESULT feeds the EX result mux in place of the alu output for M-ops.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/div_core.sv | 69 ++++++
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_muldiv_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand width, M-extension SELECT codes and the
// muldiv sequencing states.
package cpu_pkg;

    localparam int CPU_XLEN = 32;

    localparam logic [5:0] ALU_MUL    = 6'b001000;
    localparam logic [5:0] ALU_MULH   = 6'b001001;
    localparam logic [5:0] ALU_MULHSU = 6'b001010;
    localparam logic [5:0] ALU_MULHU  = 6'b001011;
    localparam logic [5:0] ALU_DIV    = 6'b001100;
    localparam logic [5:0] ALU_DIVU   = 6'b001101;
    localparam logic [5:0] ALU_REM    = 6'b001110;
    localparam logic [5:0] ALU_REMU   = 6'b001111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_RUN,
        S_DIV_FIX,
        S_DONE
    } md_state_e;

    // Every M-op lives in the 001xxx block of the SELECT space.
    function automatic logic is_mop(input logic [5:0] sel);
        return sel[5:3] == 3'b001;
    endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider iterator: one quotient bit per step, MSB first.
// The caller handles signs, special cases and sequencing.
module div_core
    import cpu_pkg::*;
#(
    parameter int W = CPU_XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         last
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    // quo_q starts out holding the dividend; its MSB shifts into the partial
    // remainder while the new quotient bit enters at the LSB.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CW'(W - 1);
        end else if (step) begin
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle M-extension unit: registered 33x33 multiplier plus a sequential
// restoring divider, with DONE handshaking for the EX-stage stall logic.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int XLEN      = CPU_XLEN,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            KILL,
    input  logic [5:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    localparam int PW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic            in_signed;
    logic            in_special;
    logic [XLEN-1:0] mag1, mag2;

    logic            core_load, core_step, core_last;
    logic [XLEN-1:0] core_quo, core_rem;

    logic signed [XLEN:0]   mul_a, mul_b;
    logic signed [PW-1:0]   prod;

    logic            fix_signed, fix_div0, fix_ovf;
    logic [XLEN-1:0] q_fix, r_fix, fix_res;

    // Launch decode works on the live inputs; the divider loads magnitudes
    // on the same edge the operands are captured.
    always_comb begin
        accept     = (state_q == S_IDLE || state_q == S_DONE) && START
                     && is_mop(SELECT) && !KILL;
        in_signed  = !SELECT[0];
        in_special = (DATA2 == '0)
                     || (in_signed && DATA1 == MIN_NEG && DATA2 == '1);
        mag1       = (in_signed && DATA1[XLEN-1]) ? -DATA1 : DATA1;
        mag2       = (in_signed && DATA2[XLEN-1]) ? -DATA2 : DATA2;
    end

    // MUL/MULH are signed x signed, MULHSU signed x unsigned, MULHU unsigned.
    always_comb begin
        mul_a = {(sel_q != 2'b11) & a_q[XLEN-1], a_q};
        mul_b = {(sel_q[1] == 1'b0) & b_q[XLEN-1], b_q};
        prod  = PW'(mul_a) * PW'(mul_b);
    end

    // Sign correction and RISC-V special cases for the divide result.
    always_comb begin
        fix_signed = !sel_q[0];
        fix_div0   = (b_q == '0);
        fix_ovf    = fix_signed && a_q == MIN_NEG && b_q == '1;
        q_fix      = (fix_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -core_quo : core_quo;
        r_fix      = (fix_signed && a_q[XLEN-1]) ? -core_rem : core_rem;
        if (fix_div0) begin
            fix_res = sel_q[1] ? a_q : '1;
        end else if (fix_ovf) begin
            fix_res = sel_q[1] ? '0 : MIN_NEG;
        end else begin
            fix_res = sel_q[1] ? r_fix : q_fix;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    sel_d = SELECT[1:0];
                    a_d   = DATA1;
                    b_d   = DATA2;
                    if (!SELECT[2]) begin
                        state_d = S_MUL;
                    end else begin
                        core_load = 1'b1;
                        state_d   = (EARLY_OUT && in_special) ? S_DIV_FIX : S_DIV_RUN;
                    end
                end
            end
            S_MUL: begin
                result_d = (sel_q == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
                state_d  = S_DONE;
            end
            S_DIV_RUN: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // A flush abandons the op but leaves the last delivered result visible.
        if (KILL) begin
            state_d   = S_IDLE;
            result_d  = result_q;
            core_step = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
        sel_q <= sel_d;
        a_q   <= a_d;
        b_q   <= b_d;
    end

    div_core #(
        .W(XLEN)
    ) u_div_core (
        .clk      (CLK),
        .rst      (RESET),
        .load     (core_load),
        .step     (core_step),
        .dividend (mag1),
        .divisor  (mag2),
        .quotient (core_quo),
        .remainder(core_rem),
        .last     (core_last)
    );

    assign RESULT = result_q;
    assign BUSY   = (state_q == S_MUL) || (state_q == S_DIV_RUN) || (state_q == S_DIV_FIX);
    assign DONE   = (state_q == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: an early-out and a full-iteration instance share the
// same stimulus and are scored against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [5:0] OP_MUL    = 6'b001000;
    localparam logic [5:0] OP_MULH   = 6'b001001;
    localparam logic [5:0] OP_MULHSU = 6'b001010;
    localparam logic [5:0] OP_MULHU  = 6'b001011;
    localparam logic [5:0] OP_DIV    = 6'b001100;
    localparam logic [5:0] OP_DIVU   = 6'b001101;
    localparam logic [5:0] OP_REM    = 6'b001110;
    localparam logic [5:0] OP_REMU   = 6'b001111;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [5:0]  sel;
    logic [31:0] d1, d2;
    logic [31:0] res_f, res_s;
    logic        busy_f, busy_s, done_f, done_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut_f (
        .CLK(clk), .RESET(rst), .START(start), .KILL(kill), .SELECT(sel),
        .DATA1(d1), .DATA2(d2), .RESULT(res_f), .BUSY(busy_f), .DONE(done_f)
    );

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut_s (
        .CLK(clk), .RESET(rst), .START(start), .KILL(kill), .SELECT(sel),
        .DATA1(d1), .DATA2(d2), .RESULT(res_s), .BUSY(busy_s), .DONE(done_s)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RISC-V M-extension semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            OP_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            OP_REMU: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    // Edges from the START-driving cycle to the cycle DONE is visible.
    function automatic int ref_lat(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input bit early);
        bit special;
        if (!op[2]) return 2;
        special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (special && early) return 2;
        return 34;
    endfunction

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stray_at,
                          output logic [31:0] rf, output logic [31:0] rs);
        logic [31:0] exp;
        int lf, ls, gf, gs, bf, bs, cyc;
        exp = ref_res(op, a, b);
        lf  = ref_lat(op, a, b, 1'b1);
        ls  = ref_lat(op, a, b, 1'b0);
        gf = -1; gs = -1; bf = 0; bs = 0;
        rf = '0; rs = '0;
        start = 1'b1; sel = op; d1 = a; d2 = b;
        tick();
        start = 1'b0; sel = 6'($urandom); d1 = $urandom; d2 = $urandom;
        cyc = 1;
        while (cyc <= 40) begin
            chk({tag, "_excl"}, {62'd0, busy_f & done_f, busy_s & done_s}, 64'd0);
            if (gf < 0) begin
                if (done_f) begin gf = cyc; rf = res_f; end
                else if (busy_f) bf++;
            end
            if (gs < 0) begin
                if (done_s) begin gs = cyc; rs = res_s; end
                else if (busy_s) bs++;
            end
            if (gf >= 0 && gs >= 0) break;
            if (cyc == stray_at) begin
                start = 1'b1; sel = OP_MUL; d1 = $urandom; d2 = $urandom;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        chk({tag, "_lat_f"}, gf, lf);
        chk({tag, "_lat_s"}, gs, ls);
        chk({tag, "_res_f"}, rf, exp);
        chk({tag, "_res_s"}, rs, exp);
        chk({tag, "_busy_f"}, bf, lf - 1);
        chk({tag, "_busy_s"}, bs, ls - 1);
    endtask

    initial begin
        logic [31:0] rf, rs, prev_f, prev_s;
        logic [5:0]  op;
        logic [31:0] a, b;
        int seen;

        rst = 1'b1; start = 1'b0; kill = 1'b0; sel = '0; d1 = '0; d2 = '0;
        repeat (2) tick();
        chk("rst_res_f", res_f, 0);
        chk("rst_res_s", res_s, 0);
        chk("rst_busy", {busy_f, busy_s}, 0);
        chk("rst_done", {done_f, done_s}, 0);
        rst = 1'b0;
        tick();

        run_op("t1_mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, rf, rs);
        chk("t1_mulh_k", rf, 32'h0000_0000);
        run_op("t1_mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, rf, rs);
        chk("t1_mulhu_k", rf, 32'hFFFF_FFFE);
        run_op("t1_mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, rf, rs);
        chk("t1_mul_k", rf, 32'h0000_0001);
        run_op("t1_mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, -1, rf, rs);
        chk("t1_mulhsu_k", rf, 32'hFFFF_FFFF);

        run_op("t2_div", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, rf, rs);
        chk("t2_div_k", rs, 32'hFFFF_FFFD);
        run_op("t2_rem", OP_REM, 32'hFFFF_FFF9, 32'd2, -1, rf, rs);
        chk("t2_rem_k", rs, 32'hFFFF_FFFF);

        run_op("t3_divu0", OP_DIVU, 32'd100, 32'd0, -1, rf, rs);
        chk("t3_divu0_k", {rf, rs}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        run_op("t3_remu0", OP_REMU, 32'd100, 32'd0, -1, rf, rs);
        chk("t3_remu0_k", {rf, rs}, {32'd100, 32'd100});
        run_op("t3_divov", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, rf, rs);
        chk("t3_divov_k", {rf, rs}, {32'h8000_0000, 32'h8000_0000});
        run_op("t3_remov", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, -1, rf, rs);
        chk("t3_remov_k", {rf, rs}, 64'd0);
        run_op("t3_rem0s", OP_REM, 32'hFFFF_FF9C, 32'd0, -1, rf, rs);
        chk("t3_rem0s_k", rs, 32'hFFFF_FF9C);

        // Flush mid-divide; a simultaneous START must lose to KILL.
        repeat (2) tick();
        prev_f = res_f; prev_s = res_s;
        start = 1'b1; sel = OP_DIV; d1 = 32'd1000; d2 = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        kill = 1'b1; start = 1'b1; sel = OP_MUL; d1 = 32'd3; d2 = 32'd5;
        tick();
        kill = 1'b0; start = 1'b0;
        chk("t4_kill_busy", {busy_f, busy_s}, 0);
        chk("t4_kill_done", {done_f, done_s}, 0);
        chk("t4_kill_res", {res_f, res_s}, {prev_f, prev_s});
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_f || done_s || busy_f || busy_s) seen++;
            tick();
        end
        chk("t4_kill_quiet", seen, 0);
        chk("t4_kill_hold", {res_f, res_s}, {prev_f, prev_s});
        run_op("t4_mul", OP_MUL, 32'd3, 32'd5, -1, rf, rs);
        chk("t4_mul_k", rf, 32'd15);

        run_op("t5_stray", OP_DIV, 32'd1000, 32'd7, 5, rf, rs);
        chk("t5_stray_k", {rf, rs}, {32'd142, 32'd142});
        chk("t5_indone", {done_f, done_s}, 2'b11);
        run_op("t5_b2b", OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, -1, rf, rs);
        chk("t5_hold", {res_f, res_s}, {rf, rs});

        for (int i = 0; i < 40; i++) begin
            op = 6'd8 + 6'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op("rnd", op, a, b, -1, rf, rs);
        end

        // Reset in the middle of a divide clears RESULT as well.
        start = 1'b1; sel = OP_DIVU; d1 = 32'd999; d2 = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_res", {res_f, res_s}, 64'd0);
        chk("t6_rst_busy", {busy_f, busy_s}, 0);
        chk("t6_rst_done", {done_f, done_s}, 0);

        start = 1'b1; sel = 6'b000000; d1 = 32'd3; d2 = 32'd5;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_f || done_s || busy_f || busy_s) seen++;
            tick();
        end
        chk("t6_nonm_quiet", seen, 0);
        chk("t6_nonm_res", {res_f, res_s}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
